// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle layout,
// ALUOp encodings and the hazard FSM state type.
package pipe_pkg;

   localparam int CTRL_W = 11;

   // Bit positions inside the decoder bundle
   // {ALUSrc, ALUOp[1:0], RegDst, MemWrite, MemRead, Beq, Bne, Jump, MemToReg, RegWrite}
   localparam int CTRL_ALUSRC   = 10;
   localparam int CTRL_ALUOP_HI = 9;
   localparam int CTRL_ALUOP_LO = 8;
   localparam int CTRL_REGDST   = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_MEMREAD  = 5;
   localparam int CTRL_BEQ      = 4;
   localparam int CTRL_BNE      = 3;
   localparam int CTRL_JUMP     = 2;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_REGWRITE = 0;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_JUMP   = 2'b11;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard equation: a load in EX whose destination
// (rt) is a source actually read by the instruction currently in ID.
module load_use_detect #(
   parameter int RW = 5
) (
   input  logic          ex_mem_read,
   input  logic          ex_valid,
   input  logic [RW-1:0] ex_rt,
   input  logic          id_jump,
   input  logic          id_reg_dst,
   input  logic          id_beq,
   input  logic          id_bne,
   input  logic          id_mem_write,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   output logic          hazard
);

   logic use_rs;
   logic use_rt;

   // Decide which ID sources are live and compare against the load target
   always_comb begin
      use_rs = ~id_jump;
      use_rt = id_reg_dst | id_beq | id_bne | id_mem_write;
      hazard = ex_mem_read & ex_valid & (ex_rt != '0) &
               ((use_rs & (ex_rt == id_rs)) | (use_rt & (ex_rt == id_rt)));
   end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall and EX-resolved flush.
// Optional event counters are enabled by defining HAZARD_STATS_EN.
module id_ex_hazard_reg
   import pipe_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DW-1:0]     id_rd1,
   input  logic [DW-1:0]     id_rd2,
   input  logic [DW-1:0]     id_imm,
   input  logic [DW-1:0]     id_pc4,
   input  logic [RW-1:0]     id_rs,
   input  logic [RW-1:0]     id_rt,
   input  logic [RW-1:0]     id_rd,
   input  logic              ex_flush,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DW-1:0]     ex_rd1,
   output logic [DW-1:0]     ex_rd2,
   output logic [DW-1:0]     ex_imm,
   output logic [DW-1:0]     ex_pc4,
   output logic [RW-1:0]     ex_rs,
   output logic [RW-1:0]     ex_rt,
   output logic [RW-1:0]     ex_rd,
   output logic              ex_valid,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic [DW-1:0]     rd1_q, rd2_q, imm_q, pc4_q;
   logic [RW-1:0]     rs_q, rt_q, rd_q;
   logic              hazard;
   logic              bubble;

   load_use_detect #(.RW(RW)) u_detect (
      .ex_mem_read  (ctrl_q[CTRL_MEMREAD]),
      .ex_valid     (valid_q),
      .ex_rt        (rt_q),
      .id_jump      (id_ctrl[CTRL_JUMP]),
      .id_reg_dst   (id_ctrl[CTRL_REGDST]),
      .id_beq       (id_ctrl[CTRL_BEQ]),
      .id_bne       (id_ctrl[CTRL_BNE]),
      .id_mem_write (id_ctrl[CTRL_MEMWRITE]),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .hazard       (hazard)
   );

   // Next-state: flush beats stall; the stall state masks detection so a stall lasts one cycle
   always_comb begin
      state_d     = ST_RUN;
      bubble      = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if (ex_flush) begin
         bubble = 1'b1;
      end else if ((state_q == ST_RUN) && hazard) begin
         state_d     = ST_STALL;
         bubble      = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end
      ctrl_d      = bubble ? '0 : id_ctrl;
      valid_d     = ~bubble;
      if_id_flush = ex_flush;
   end

   // EX stage register; datapath fields are captured even when a bubble is inserted
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         ctrl_q  <= '0;
         valid_q <= 1'b0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc4_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
         rd1_q   <= id_rd1;
         rd2_q   <= id_rd2;
         imm_q   <= id_imm;
         pc4_q   <= id_pc4;
         rs_q    <= id_rs;
         rt_q    <= id_rt;
         rd_q    <= id_rd;
      end
   end

   assign ex_ctrl  = ctrl_q;
   assign ex_valid = valid_q;
   assign ex_rd1   = rd1_q;
   assign ex_rd2   = rd2_q;
   assign ex_imm   = imm_q;
   assign ex_pc4   = pc4_q;
   assign ex_rs    = rs_q;
   assign ex_rt    = rt_q;
   assign ex_rd    = rd_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Event counters wrap naturally at 32 bits
   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, ~pc_write};
      flush_cnt_d = flush_cnt_q + {31'd0, ex_flush};
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed testbench for id_ex_hazard_reg. Counter checks are compiled in when
// HAZARD_STATS_EN is defined; otherwise the counter ports must read zero.
module tb_id_ex_hazard_reg;

   localparam logic [10:0] C_LW   = 11'h423; // ALUSrc, MemRead, MemToReg, RegWrite
   localparam logic [10:0] C_ADD  = 11'h281; // ALUOp=10, RegDst, RegWrite
   localparam logic [10:0] C_BEQ  = 11'h110; // ALUOp=01, Beq
   localparam logic [10:0] C_JUMP = 11'h304; // ALUOp=11, Jump

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] id_ctrl;
   logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        ex_flush;
   logic [10:0] ex_ctrl;
   logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic        ex_valid, pc_write, if_id_write, if_id_flush;
   logic [31:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   id_ex_hazard_reg #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst(rst), .id_ctrl(id_ctrl),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_flush(ex_flush),
      .ex_ctrl(ex_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_pc4(ex_pc4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] tag);
      id_ctrl = c;
      id_rs   = rs;
      id_rt   = rt;
      id_rd   = rd;
      id_rd1  = tag;
      id_rd2  = tag + 32'h10;
      id_imm  = tag + 32'h20;
      id_pc4  = tag + 32'h30;
      #1;
   endtask

   // Advance one clock; outputs are observed 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      ex_flush = 1'b0;
      set_id(11'h0, 5'd0, 5'd0, 5'd0, 32'h0);
      tick();
      tick();
      chk("rst_ctrl", {21'd0, ex_ctrl}, 32'h0);
      chk("rst_valid", {31'd0, ex_valid}, 32'h0);
      chk("rst_rd1", ex_rd1, 32'h0);
      chk("rst_pcw", {31'd0, pc_write}, 32'h1);
      chk("rst_ifidw", {31'd0, if_id_write}, 32'h1);
      chk("rst_scnt", stall_cnt, 32'h0);
      rst = 1'b0;

      // lw $8,0($9) into EX
      set_id(C_LW, 5'd9, 5'd8, 5'd0, 32'h100);
      tick();
      chk("lw_ctrl", {21'd0, ex_ctrl}, {21'd0, C_LW});
      chk("lw_valid", {31'd0, ex_valid}, 32'h1);
      chk("lw_rt", {27'd0, ex_rt}, 32'd8);
      chk("lw_pc4", ex_pc4, 32'h130);

      // add $9,$8,$10 -> one-cycle stall on rs
      set_id(C_ADD, 5'd8, 5'd10, 5'd9, 32'h200);
      chk("rs_pcw", {31'd0, pc_write}, 32'h0);
      chk("rs_ifidw", {31'd0, if_id_write}, 32'h0);
      chk("rs_flush", {31'd0, if_id_flush}, 32'h0);
      tick();
      chk("bub_ctrl", {21'd0, ex_ctrl}, 32'h0);
      chk("bub_valid", {31'd0, ex_valid}, 32'h0);
      chk("bub_rd1", ex_rd1, 32'h200);
      chk("stl_pcw", {31'd0, pc_write}, 32'h1);
`ifdef HAZARD_STATS_EN
      chk("stl_scnt", stall_cnt, 32'h1);
`endif
      tick();
      chk("add_ctrl", {21'd0, ex_ctrl}, {21'd0, C_ADD});
      chk("add_valid", {31'd0, ex_valid}, 32'h1);
      chk("add_rd", {27'd0, ex_rd}, 32'd9);

      // rt not a source for lw in ID -> no stall
      set_id(C_LW, 5'd9, 5'd8, 5'd0, 32'h300);
      tick();
      set_id(C_LW, 5'd12, 5'd8, 5'd0, 32'h400);
      chk("rtun_pcw", {31'd0, pc_write}, 32'h1);
      tick();
      chk("rtun_valid", {31'd0, ex_valid}, 32'h1);
      chk("rtun_rd1", ex_rd1, 32'h400);

      // beq reads rt -> stall (EX still holds lw with rt=8)
      set_id(C_BEQ, 5'd3, 5'd8, 5'd0, 32'h500);
      chk("beq_pcw", {31'd0, pc_write}, 32'h0);
      tick();
      tick();
      chk("beq_ctrl", {21'd0, ex_ctrl}, {21'd0, C_BEQ});

      // jump does not read rs
      set_id(C_LW, 5'd9, 5'd8, 5'd0, 32'h600);
      tick();
      set_id(C_JUMP, 5'd8, 5'd0, 5'd0, 32'h700);
      chk("jmp_pcw", {31'd0, pc_write}, 32'h1);
      tick();
      chk("jmp_valid", {31'd0, ex_valid}, 32'h1);

      // Flush priority over hazard, from clean counters
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_id(C_LW, 5'd9, 5'd8, 5'd0, 32'h800);
      tick();
      set_id(C_ADD, 5'd8, 5'd10, 5'd9, 32'h900);
      ex_flush = 1'b1;
      #1;
      chk("fl_pcw", {31'd0, pc_write}, 32'h1);
      chk("fl_ifidw", {31'd0, if_id_write}, 32'h1);
      chk("fl_ifidf", {31'd0, if_id_flush}, 32'h1);
      tick();
      ex_flush = 1'b0;
      #1;
      chk("fl_ctrl", {21'd0, ex_ctrl}, 32'h0);
      chk("fl_valid", {31'd0, ex_valid}, 32'h0);
      chk("fl_ifidf0", {31'd0, if_id_flush}, 32'h0);
`ifdef HAZARD_STATS_EN
      chk("fl_fcnt", flush_cnt, 32'h1);
      chk("fl_scnt", stall_cnt, 32'h0);
`else
      chk("fl_fcnt0", flush_cnt, 32'h0);
`endif
      tick();
      chk("fl_next", {21'd0, ex_ctrl}, {21'd0, C_ADD});
      chk("fl_nvalid", {31'd0, ex_valid}, 32'h1);

      // $zero immunity
      set_id(C_LW, 5'd9, 5'd0, 5'd0, 32'hA00);
      tick();
      set_id(C_ADD, 5'd0, 5'd10, 5'd9, 32'hB00);
      chk("zero_pcw", {31'd0, pc_write}, 32'h1);
      tick();
      chk("zero_valid", {31'd0, ex_valid}, 32'h1);

      // Reset asserted in the stall cycle
      set_id(C_LW, 5'd9, 5'd8, 5'd0, 32'hC00);
      tick();
      set_id(C_ADD, 5'd8, 5'd10, 5'd9, 32'hD00);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mrst_ctrl", {21'd0, ex_ctrl}, 32'h0);
      chk("mrst_valid", {31'd0, ex_valid}, 32'h0);
      chk("mrst_rt", {27'd0, ex_rt}, 32'h0);
      chk("mrst_scnt", stall_cnt, 32'h0);
      chk("mrst_fcnt", flush_cnt, 32'h0);
      chk("mrst_pcw", {31'd0, pc_write}, 32'h1);

`ifdef HAZARD_STATS_EN
      // Stall counter wrap
      set_id(C_LW, 5'd9, 5'd8, 5'd0, 32'hE00);
      tick();
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      set_id(C_ADD, 5'd8, 5'd10, 5'd9, 32'hF00);
      chk("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
      tick();
      chk("wrap_cnt", stall_cnt, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
